mem_bridge: RTL and testbench

//  Sits between the datapath memory port and the single-port system memory bus.

---
 rtl/mem_bridge.sv | 103 ++++++++++
 tb/tb_mem_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
// mem_bridge: turns the core's level-held read/write requests into req/gnt/rvalid bus beats and stalls the core until done
//   clk_i, reset_i (async, active-low)
//   core: rd_req_i/rd_addr_i, wr_req_i/wr_addr_i/wr_data_i/wr_be_i in; stall_o, done_o, rd_valid_o, rd_data_o, err_o out
//   bus:  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o out; bus_gnt_i, bus_rvalid_i, bus_rdata_i in
module mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rd_req_i,
    input  logic [31:0] rd_addr_i,
    input  logic        wr_req_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [3:0]  wr_be_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);
    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE} state_t;
    state_t      state;
    logic        rd_op;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [31:0] cnt;
    logic        timeout;
    // cnt holds the number of cycles already spent in RD_REQ/RD_WAIT; this cycle is the last one allowed
    assign timeout = (TIMEOUT_CYCLES != 32'd0) && (cnt + 32'd1 == TIMEOUT_CYCLES);
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            rd_op     <= 1'b0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_be     <= '0;
            cnt       <= '0;
            rd_data_o <= '0;
            err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (rd_req_i || wr_req_i) begin
                    rd_op   <= rd_req_i;
                    rd_addr <= rd_addr_i;
                    wr_addr <= wr_addr_i;
                    wr_data <= wr_data_i;
                    wr_be   <= wr_be_i;
                    cnt     <= '0;
                    state   <= wr_req_i ? WR_REQ : RD_REQ;
                end
                WR_REQ: if (bus_gnt_i) begin
                    cnt   <= '0;
                    state <= rd_op ? RD_REQ : DONE;
                end
                RD_REQ: begin
                    cnt <= cnt + 32'd1;
                    if (timeout) begin
                        err_o     <= 1'b1;
                        rd_data_o <= 32'hDEAD_BEEF;
                        state     <= DONE;
                    end else if (bus_gnt_i) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt + 32'd1;
                    // data arriving on the last allowed cycle beats the timeout
                    if (bus_rvalid_i) begin
                        rd_data_o <= bus_rdata_i;
                        state     <= DONE;
                    end else if (timeout) begin
                        err_o     <= 1'b1;
                        rd_data_o <= 32'hDEAD_BEEF;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // gated by reset_i so a held request cannot keep the core stalled while in reset
    assign stall_o     = reset_i && ((state inside {WR_REQ, RD_REQ, RD_WAIT}) || (state == IDLE && (rd_req_i || wr_req_i)));
    assign done_o      = state == DONE;
    assign rd_valid_o  = done_o && rd_op;
    assign bus_req_o   = state == WR_REQ || state == RD_REQ;
    assign bus_we_o    = state == WR_REQ;
    assign bus_addr_o  = (state == WR_REQ ? wr_addr : state == RD_REQ ? rd_addr : 32'h0) & 32'hFFFF_FFFC;
    assign bus_wdata_o = state == WR_REQ ? wr_data : 32'h0;
    assign bus_be_o    = state == WR_REQ ? wr_be : state == RD_REQ ? 4'hF : 4'h0;
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed vector table plus hand-written corner sequences for mem_bridge
module tb_mem_bridge;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        rd_req_i = 1'b0;
    logic [31:0] rd_addr_i = '0;
    logic        wr_req_i = 1'b0;
    logic [31:0] wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic [3:0]  wr_be_i = '0;
    logic        stall_o, done_o, rd_valid_o, err_o;
    logic [31:0] rd_data_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    int checks = 0;
    int failures = 0;

    mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
        .stall_o(stall_o), .done_o(done_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    // flags = {stall, done, rd_valid, bus_req, bus_we, err}
    typedef struct {
        logic        rd, wr, gnt, rv;
        logic [31:0] rdata;
        logic [5:0]  flags;
        logic [31:0] addr;
        logic        chk_d;
        logic [31:0] exp_d;
    } vec_t;

    function automatic vec_t mk(logic rd, logic wr, logic gnt, logic rv, logic [31:0] rdata,
                                logic [5:0] flags, logic [31:0] addr, logic chk_d, logic [31:0] exp_d);
        vec_t v;
        v.rd = rd; v.wr = wr; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.flags = flags; v.addr = addr; v.chk_d = chk_d; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[21];
        int   n;
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,         6'b100000, 32'h0,   0, 32'h0);
        tbl[1]  = mk(1, 0, 1, 0, 32'h0,         6'b100100, 32'h100, 0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 1, 32'hCAFEF00D,  6'b100000, 32'h0,   0, 32'h0);
        tbl[3]  = mk(1, 0, 0, 0, 32'h0,         6'b011000, 32'h0,   1, 32'hCAFEF00D);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,         6'b000000, 32'h0,   1, 32'hCAFEF00D);
        tbl[5]  = mk(1, 1, 0, 0, 32'h0,         6'b100000, 32'h0,   0, 32'h0);
        tbl[6]  = mk(1, 1, 0, 0, 32'h0,         6'b100110, 32'h204, 0, 32'h0);
        tbl[7]  = mk(1, 1, 1, 0, 32'h0,         6'b100110, 32'h204, 0, 32'h0);
        tbl[8]  = mk(1, 1, 1, 1, 32'hBAD0BAD0,  6'b100100, 32'h100, 0, 32'h0);
        tbl[9]  = mk(1, 1, 0, 0, 32'h0,         6'b100000, 32'h0,   1, 32'hCAFEF00D);
        tbl[10] = mk(1, 1, 0, 1, 32'h12345678,  6'b100000, 32'h0,   0, 32'h0);
        tbl[11] = mk(1, 1, 0, 0, 32'h0,         6'b011000, 32'h0,   1, 32'h12345678);
        tbl[12] = mk(1, 0, 0, 0, 32'h0,         6'b100000, 32'h0,   0, 32'h0);
        tbl[13] = mk(1, 0, 1, 0, 32'h0,         6'b100100, 32'h100, 0, 32'h0);
        tbl[14] = mk(1, 0, 0, 1, 32'hA5A5A5A5,  6'b100000, 32'h0,   0, 32'h0);
        tbl[15] = mk(1, 0, 0, 0, 32'h0,         6'b011000, 32'h0,   1, 32'hA5A5A5A5);
        tbl[16] = mk(1, 0, 0, 0, 32'h0,         6'b100000, 32'h0,   0, 32'h0);
        tbl[17] = mk(1, 0, 1, 0, 32'h0,         6'b100100, 32'h100, 0, 32'h0);
        tbl[18] = mk(1, 0, 0, 1, 32'h0F0F0F0F,  6'b100000, 32'h0,   0, 32'h0);
        tbl[19] = mk(1, 0, 0, 0, 32'h0,         6'b011000, 32'h0,   1, 32'h0F0F0F0F);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,         6'b000000, 32'h0,   1, 32'h0F0F0F0F);

        // reset state
        @(negedge clk);
        #1;
        chk("reset_outputs",
            {stall_o, done_o, rd_valid_o, err_o, bus_req_o, bus_we_o, rd_data_o, bus_addr_o, bus_wdata_o, bus_be_o},
            '0);
        @(negedge clk);
        reset_i = 1'b1;

        // read, write+read with gnt-cycle rvalid, back-to-back reads held across DONE
        rd_addr_i = 32'h103;
        wr_addr_i = 32'h206;
        wr_data_i = 32'h55AA55AA;
        wr_be_i   = 4'b1010;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            rd_req_i     = tbl[i].rd;
            wr_req_i     = tbl[i].wr;
            bus_gnt_i    = tbl[i].gnt;
            bus_rvalid_i = tbl[i].rv;
            bus_rdata_i  = tbl[i].rdata;
            #1;
            chk($sformatf("vec%0d_flags_addr", i),
                {stall_o, done_o, rd_valid_o, bus_req_o, bus_we_o, err_o, bus_addr_o},
                {tbl[i].flags, tbl[i].addr});
            if (tbl[i].chk_d) chk($sformatf("vec%0d_rd_data", i), rd_data_o, tbl[i].exp_d);
        end

        // write with gnt held off for 5 cycles
        @(negedge clk);
        wr_addr_i = 32'h204;
        wr_data_i = 32'h11223344;
        wr_be_i   = 4'b0011;
        wr_req_i  = 1'b1;
        #1;
        chk("wr_idle_stall", {stall_o, bus_req_o}, 2'b10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus_gnt_i = (i == 5);
            #1;
            chk($sformatf("wr_beat%0d", i),
                {stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o},
                {3'b111, 32'h204, 32'h11223344, 4'b0011});
        end
        @(negedge clk);
        bus_gnt_i = 1'b0;
        #1;
        chk("wr_done", {stall_o, done_o, rd_valid_o, bus_req_o, err_o}, 5'b01000);
        chk("wr_rd_data_kept", rd_data_o, 32'h0F0F0F0F);
        @(negedge clk);
        wr_req_i = 1'b0;

        // read timeout: rvalid never arrives
        @(negedge clk);
        rd_addr_i = 32'h301;
        rd_req_i  = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus_gnt_i = (i == 0);
            #1;
            if (i == 0) chk("to_rd_beat", {bus_req_o, bus_we_o, bus_be_o, bus_addr_o}, {2'b10, 4'hF, 32'h300});
            if (done_o) break;
            n++;
        end
        chk("to_cycles", n, 8);
        chk("to_done", {done_o, rd_valid_o, err_o, bus_req_o}, 4'b1110);
        chk("to_rd_data", rd_data_o, 32'hDEADBEEF);
        @(negedge clk);
        rd_req_i  = 1'b0;
        bus_gnt_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("to_err_sticky", {err_o, stall_o}, 2'b10);

        // asynchronous reset while in RD_WAIT
        @(negedge clk);
        rd_addr_i = 32'h400;
        rd_req_i  = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b0;
        #1;
        chk("rst_pre", {stall_o, bus_req_o, err_o}, 3'b101);
        #2;
        reset_i = 1'b0;
        #1;
        chk("rst_async", {bus_req_o, stall_o, err_o, done_o, rd_data_o}, '0);
        @(negedge clk);
        reset_i  = 1'b1;
        rd_req_i = 1'b0;
        #1;
        chk("rst_idle", {stall_o, done_o, bus_req_o, err_o}, 4'b0000);

        // rvalid on the final allowed cycle wins over the timeout
        @(negedge clk);
        rd_addr_i = 32'h500;
        rd_req_i  = 1'b1;
        @(negedge clk);
        bus_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus_gnt_i = 1'b0;
        end
        @(negedge clk);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h600DF00D;
        #1;
        chk("race_last_wait", {stall_o, done_o}, 2'b10);
        @(negedge clk);
        bus_rvalid_i = 1'b0;
        #1;
        chk("race_done", {done_o, rd_valid_o, err_o}, 3'b110);
        chk("race_rd_data", rd_data_o, 32'h600DF00D);
        @(negedge clk);
        rd_req_i = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
